// File: rtl/frame_rx_pkg.sv
// Shared types and constants for the frame_rx deframer.
// Optional statistics counters are enabled with FRAME_RX_STATS_EN.
package frame_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        TERM,
        DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef struct packed {
        logic       last;
        logic       err;
        logic [7:0] data;
    } fifo_entry_t;

    // Reflected CRC32, one byte processed LSB-first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_rx_fifo.sv
// Synchronous show-ahead FIFO of frame entries; head is valid whenever count is non-zero.
module frame_rx_fifo
    import frame_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fifo_entry_t              push_entry,
    input  logic                     pop,
    output fifo_entry_t              head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign valid   = (count != '0);
    assign push_ok = push && (count != CNT_FULL);
    assign pop_ok  = pop && valid;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_rx.sv
// Deframer: strips preamble/SFD, checks and removes the CRC32 FCS, queues payload entries.
// Define FRAME_RX_STATS_EN to add the frames_ok / frames_err counters.
module frame_rx
    import frame_rx_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PRE_MIN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_en,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf_sticky
`ifdef FRAME_RX_STATS_EN
    ,
    output logic [31:0] frames_ok,
    output logic [31:0] frames_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_RSV   = (AW + 1)'(DEPTH - 1);
    localparam logic [7:0]  PRE_MIN_B = 8'(PRE_MIN);

    state_t      state, state_next;
    logic        rx_en_q;
    logic [7:0]  pre_cnt, pre_next;
    logic [2:0]  n_cnt, n_next;
    logic [31:0] crc, crc_next;
    logic        frame_ovf, fovf_next;
    logic [7:0]  dl [5];
    logic        shift;
    logic        push;
    logic        term_push;
    logic        ovf_set;
    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        fifo_valid;
    logic [AW:0] fifo_count;

    frame_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (out_valid && out_ready),
        .head       (head),
        .valid      (fifo_valid),
        .count      (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign out_data  = fifo_valid ? head.data : '0;
    assign out_last  = fifo_valid & head.last;
    assign out_err   = fifo_valid & head.err;

    always_comb begin
        state_next = state;
        pre_next   = pre_cnt;
        n_next     = n_cnt;
        crc_next   = crc;
        fovf_next  = frame_ovf;
        shift      = 1'b0;
        push       = 1'b0;
        term_push  = 1'b0;
        ovf_set    = 1'b0;
        push_entry = '0;
        case (state)
            IDLE: begin
                // rx_en_q resets high so a frame already in flight at reset release is ignored
                if (rx_en && !rx_en_q) begin
                    if (rx_data == PREAMBLE_BYTE) begin
                        state_next = PRE;
                        pre_next   = 8'd1;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            PRE: begin
                if (!rx_en) begin
                    state_next = DROP;
                end else if (rx_data == PREAMBLE_BYTE) begin
                    if (pre_cnt != 8'hFF) pre_next = pre_cnt + 8'd1;
                end else if (rx_data == SFD_BYTE && pre_cnt >= PRE_MIN_B) begin
                    state_next = DATA;
                    crc_next   = CRC_INIT;
                    n_next     = 3'd0;
                    fovf_next  = 1'b0;
                end else begin
                    state_next = DROP;
                end
            end
            DATA: begin
                if (!rx_en) begin
                    state_next = TERM;
                end else begin
                    crc_next = crc32_byte(crc, rx_data);
                    shift    = 1'b1;
                    if (n_cnt == 3'd5) begin
                        // the final FIFO slot stays free for the frame-end entry
                        if (!frame_ovf && fifo_count < CNT_RSV) begin
                            push            = 1'b1;
                            push_entry.data = dl[4];
                        end else begin
                            ovf_set   = 1'b1;
                            fovf_next = 1'b1;
                        end
                    end else begin
                        n_next = n_cnt + 3'd1;
                    end
                end
            end
            TERM: begin
                if (fifo_count != CNT_FULL) begin
                    push            = 1'b1;
                    term_push       = 1'b1;
                    push_entry.last = 1'b1;
                    if (n_cnt == 3'd5 && !frame_ovf) begin
                        push_entry.data = dl[4];
                        push_entry.err  = (crc != CRC_RESIDUE);
                    end else begin
                        push_entry.err  = 1'b1;
                    end
                    state_next = rx_en ? DROP : IDLE;
                end else if (rx_en) begin
                    ovf_set = 1'b1;
                end
            end
            DROP: begin
                if (!rx_en) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rx_en_q    <= 1'b1;
            pre_cnt    <= '0;
            n_cnt      <= '0;
            crc        <= CRC_INIT;
            frame_ovf  <= 1'b0;
            ovf_sticky <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) dl[i] <= '0;
        end else begin
            state     <= state_next;
            rx_en_q   <= rx_en;
            pre_cnt   <= pre_next;
            n_cnt     <= n_next;
            crc       <= crc_next;
            frame_ovf <= fovf_next;
            if (ovf_set) ovf_sticky <= 1'b1;
            if (shift) begin
                for (int unsigned i = 4; i > 0; i--) dl[i] <= dl[i-1];
                dl[0] <= rx_data;
            end
        end
    end

`ifdef FRAME_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_ok  <= '0;
            frames_err <= '0;
        end else if (term_push) begin
            if (push_entry.err) frames_err <= frames_err + 32'd1;
            else                frames_ok  <= frames_ok + 32'd1;
        end
    end
`endif

endmodule
